// File: rtl/rvc_imem_loader_5pl_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package rvc_imem_loader_5pl_pkg;

  // Loader FSM states, in frame order.
  typedef enum logic [2:0] {
    LDR_LEN0,
    LDR_LEN1,
    LDR_DATA,
    LDR_CSUM,
    LDR_DONE,
    LDR_ERR
  } t_ldr_state;

  // Frame header: little-endian word count.
  localparam int LDR_LEN_BYTES = 2;
  localparam int LDR_LEN_W     = 8 * LDR_LEN_BYTES;

endpackage

// File: rtl/rvc_imem_loader_5pl_if.sv
// Host byte stream, I_MEM write port and boot status of the loader.
interface rvc_imem_loader_5pl_if #(
  parameter int IMEM_ADDR_W = 10
);
  logic                   ByteValid;
  logic [7:0]             ByteData;
  logic                   ByteReady;
  logic                   Restart;
  logic                   ImemWrEn;
  logic [IMEM_ADDR_W-1:0] ImemWrAddr;
  logic [31:0]            ImemWrData;
  logic                   CoreHold;
  logic                   LoadDone;
  logic                   LoadErr;

  // Host / boot controller side.
  modport master (
    output ByteValid, ByteData, Restart,
    input  ByteReady, ImemWrEn, ImemWrAddr, ImemWrData, CoreHold, LoadDone, LoadErr
  );

  // Loader side.
  modport slave (
    input  ByteValid, ByteData, Restart,
    output ByteReady, ImemWrEn, ImemWrAddr, ImemWrData, CoreHold, LoadDone, LoadErr
  );
endinterface

// File: rtl/rvc_imem_loader_5pl.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image from a
// host, writes it word by word into I_MEM from address 0 and releases the
// core from reset only once the image is complete and verified.
module rvc_imem_loader_5pl
  import rvc_imem_loader_5pl_pkg::*;
#(
  parameter int IMEM_WORDS  = 1024,
  parameter int IMEM_ADDR_W = $clog2(IMEM_WORDS)
) (
  input  logic                     Clock,
  input  logic                     Rst,
  rvc_imem_loader_5pl_if.slave     bus
);

  // Largest legal word count, one bit wider than the header so the compare cannot overflow.
  localparam logic [LDR_LEN_W:0] MAX_N = (LDR_LEN_W + 1)'(IMEM_WORDS);

  t_ldr_state             state_q;
  logic [LDR_LEN_W-1:0]   nwords_q;
  logic [IMEM_ADDR_W:0]   cnt_q;      // one extra bit: counts up to IMEM_WORDS without wrapping
  logic [1:0]             lane_q;
  logic [7:0]             csum_q;
  logic                   ready_q;
  logic                   wr_en_q;
  logic [IMEM_ADDR_W-1:0] wr_addr_q;
  logic [31:0]            wr_data_q;
  logic                   hold_q;
  logic                   done_q;
  logic                   err_q;

  logic                   take;
  logic [LDR_LEN_W-1:0]   n_full;
  logic                   too_long;
  logic                   last_word;

  assign take      = bus.ByteValid & ready_q;
  assign n_full    = {bus.ByteData, nwords_q[7:0]};
  assign too_long  = {1'b0, n_full} > MAX_N;
  assign last_word = (LDR_LEN_W'(cnt_q) + LDR_LEN_W'(1)) == nwords_q;

  // Frame parser, byte assembly and registered I_MEM write / status outputs.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state_q   <= LDR_LEN0;
      nwords_q  <= '0;
      cnt_q     <= '0;
      lane_q    <= '0;
      csum_q    <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        LDR_LEN0: begin
          // Ready rises here on the first cycle after reset is released.
          ready_q <= 1'b1;
          if (take) begin
            nwords_q[7:0] <= bus.ByteData;
            state_q       <= LDR_LEN1;
          end
        end
        LDR_LEN1: begin
          if (take) begin
            nwords_q <= n_full;
            cnt_q    <= '0;
            lane_q   <= '0;
            if (too_long) begin
              state_q <= LDR_ERR;
              ready_q <= 1'b0;
              err_q   <= 1'b1;
            end else if (n_full == '0) begin
              state_q <= LDR_CSUM;
            end else begin
              state_q <= LDR_DATA;
            end
          end
        end
        LDR_DATA: begin
          if (take) begin
            wr_data_q[8*lane_q +: 8] <= bus.ByteData;
            csum_q                   <= csum_q ^ bus.ByteData;
            lane_q                   <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cnt_q[IMEM_ADDR_W-1:0];
              cnt_q     <= cnt_q + (IMEM_ADDR_W + 1)'(1);
              if (last_word) begin
                state_q <= LDR_CSUM;
              end
            end
          end
        end
        LDR_CSUM: begin
          if (take) begin
            ready_q <= 1'b0;
            if (bus.ByteData == csum_q) begin
              state_q <= LDR_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= LDR_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        LDR_DONE, LDR_ERR: begin
          // Ready is low here, so a byte offered alongside Restart is never consumed.
          if (bus.Restart) begin
            state_q   <= LDR_LEN0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            hold_q    <= 1'b1;
            csum_q    <= '0;
            cnt_q     <= '0;
            lane_q    <= '0;
            wr_addr_q <= '0;
          end
        end
        default: state_q <= LDR_LEN0;
      endcase
    end
  end

  assign bus.ByteReady  = ready_q;
  assign bus.ImemWrEn   = wr_en_q;
  assign bus.ImemWrAddr = wr_addr_q;
  assign bus.ImemWrData = wr_data_q;
  assign bus.CoreHold   = hold_q;
  assign bus.LoadDone   = done_q;
  assign bus.LoadErr    = err_q;

endmodule
